// File: rtl/gps_iq_packer_if.sv
// gps_iq_packer_if: AXI-Stream word channel from the IQ packer toward DMA/host capture.
interface gps_iq_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/gps_iq_packer.sv
// gps_iq_packer: decimates the emulator I/Q stream and packs two pairs per word into an FWFT FIFO.
// Optional macro GPS_IQ_PACK_TLAST_EN adds packet framing on tlast every PKT_WORDS words.
module gps_iq_packer #(
    parameter int SAMPLE_DIV = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_WORDS  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       real_in,
    input  logic [7:0]       imag_in,
    output logic             sample_strobe,
    output logic [15:0]      overflow_count,
    gps_iq_packer_if.master  m
);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] div;
    logic          lane;
    logic [15:0]   half;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, push, push_ok;

    always_comb begin
        sample_strobe = enable && div == DW'(SAMPLE_DIV - 1);
        empty         = wptr == rptr;
        full          = wptr == {~rptr[AW], rptr[AW-1:0]};
        pop           = !empty && m.tready;
        push          = sample_strobe && lane;
        // a full FIFO still accepts when the head leaves in the same cycle
        push_ok       = push && (!full || pop);
    end

    assign m.tvalid = !empty;
    assign m.tdata  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            div            <= '0;
            lane           <= 1'b0;
            half           <= '0;
            wptr           <= '0;
            rptr           <= '0;
            overflow_count <= '0;
        end else begin
            div  <= (!enable || sample_strobe) ? '0 : div + 1'b1;
            lane <= enable && (sample_strobe ? !lane : lane);
            half <= !enable ? '0 : (sample_strobe && !lane) ? {imag_in, real_in} : half;
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !push_ok && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push_ok)
            mem[wptr[AW-1:0]] <= {imag_in, real_in, half};

`ifdef GPS_IQ_PACK_TLAST_EN
    localparam int PW = PKT_WORDS > 1 ? $clog2(PKT_WORDS) : 1;
    logic [PW-1:0] pkt;
    logic          pkt_end;

    always_comb pkt_end = pkt == PW'(PKT_WORDS - 1);

    always_ff @(posedge clk) begin
        if (reset)
            pkt <= '0;
        else if (pop)
            pkt <= pkt_end ? '0 : pkt + 1'b1;
    end

    assign m.tlast = !empty && pkt_end;
`else
    assign m.tlast = 1'b0;
`endif
endmodule

// File: tb/tb_gps_iq_packer.sv
// tb_gps_iq_packer: directed checks of divider, packing, FIFO overflow/drain, reset and tlast.
module tb_gps_iq_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  real_in = '0;
    logic [7:0]  imag_in = '0;
    logic        sample_strobe;
    logic [15:0] overflow_count;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;

    gps_iq_packer_if axis ();

    gps_iq_packer #(.SAMPLE_DIV(25), .FIFO_DEPTH(16), .PKT_WORDS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .real_in        (real_in),
        .imag_in        (imag_in),
        .sample_strobe  (sample_strobe),
        .overflow_count (overflow_count),
        .m              (axis)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rv(input int s);
        logic [7:0] v;
        v = s[7:0];
        return v;
    endfunction

    function automatic logic [7:0] iv(input int s);
        return rv(s) ^ 8'hA5;
    endfunction

    // word formed by samples s (lane 0) and s+1 (lane 1)
    function automatic logic [31:0] word(input int s);
        return {iv(s + 1), rv(s + 1), iv(s), rv(s)};
    endfunction

    // waits for the strobe, optionally raising tready only in the strobe cycle, then passes the capture edge
    task automatic capture(input logic [7:0] r, input logic [7:0] i, input bit pulse, output int cyc);
        real_in = r;
        imag_in = i;
        cyc = 0;
        while (!sample_strobe && cyc < 100) begin
            tick();
            cyc++;
        end
        if (cyc >= 100) chk("strobe_timeout", 32'd0, 32'd1);
        if (pulse) begin
            axis.tready = 1'b1;
            tick();
            axis.tready = 1'b0;
        end else
            tick();
    endtask

    task automatic cap(input int s);
        int c;
        capture(rv(s), iv(s), 1'b0, c);
    endtask

    initial begin
        axis.tready = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("rst_tdata", axis.tdata, 32'd0);
        chk("rst_tlast", {31'd0, axis.tlast}, 32'd0);
        chk("rst_strobe", {31'd0, sample_strobe}, 32'd0);
        chk("rst_ovf", {16'd0, overflow_count}, 32'd0);

        // 1: first strobe in the 25th enabled cycle, then every 25 cycles; one word, valid 1 cycle
        reset = 1'b0;
        enable = 1'b1;
        capture(8'h01, 8'h81, 1'b0, n);
        chk("t1_first_strobe_wait", n, 32'd24);
        chk("t1_no_word_after_lane0", {31'd0, axis.tvalid}, 32'd0);
        capture(8'h02, 8'h82, 1'b0, n);
        chk("t1_strobe_spacing", n, 32'd24);
        chk("t1_tvalid", {31'd0, axis.tvalid}, 32'd1);
        chk("t1_tdata", axis.tdata, 32'h82028101);
        tick();
        chk("t1_tvalid_one_cycle", {31'd0, axis.tvalid}, 32'd0);

        // 2: 20 words into a 16-deep FIFO with tready low, then drain in order
        axis.tready = 1'b0;
        for (int k = 0; k < 40; k++) cap(k);
        chk("t2_ovf", {16'd0, overflow_count}, 32'd4);
        chk("t2_tvalid_held", {31'd0, axis.tvalid}, 32'd1);
        chk("t2_head_stable", axis.tdata, word(0));
        axis.tready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("t2_drain%0d", j), axis.tdata, word(2 * j));
            tick();
        end
        chk("t2_empty", {31'd0, axis.tvalid}, 32'd0);

        // 4: full FIFO, pop and push in the same cycle
        axis.tready = 1'b0;
        for (int k = 100; k < 133; k++) cap(k);
        chk("t4_ovf_before", {16'd0, overflow_count}, 32'd4);
        capture(rv(133), iv(133), 1'b1, n);
        chk("t4_ovf_after", {16'd0, overflow_count}, 32'd4);
        axis.tready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            chk($sformatf("t4_drain%0d", j), axis.tdata, word(100 + 2 * j));
            tick();
        end
        chk("t4_empty", {31'd0, axis.tvalid}, 32'd0);

        // 3: enable drop after an odd capture discards the held half-word
        cap(200);
        enable = 1'b0;
        repeat (3) tick();
        chk("t3_no_word_disabled", {31'd0, axis.tvalid}, 32'd0);
        enable = 1'b1;
        capture(rv(201), iv(201), 1'b0, n);
        chk("t3_strobe_after_rise", n, 32'd24);
        chk("t3_lane_reset", {31'd0, axis.tvalid}, 32'd0);
        cap(202);
        chk("t3_tvalid", {31'd0, axis.tvalid}, 32'd1);
        chk("t3_tdata", axis.tdata, word(201));

        // 5: reset with 5 words held and overflow_count=3
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        enable = 1'b1;
        axis.tready = 1'b0;
        chk("t5_ovf_cleared", {16'd0, overflow_count}, 32'd0);
        for (int k = 300; k < 338; k++) cap(k);
        axis.tready = 1'b1;
        repeat (11) tick();
        axis.tready = 1'b0;
        chk("t5_ovf3", {16'd0, overflow_count}, 32'd3);
        chk("t5_head", axis.tdata, word(322));
        reset = 1'b1;
        tick();
        chk("t5_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("t5_ovf", {16'd0, overflow_count}, 32'd0);
        chk("t5_strobe", {31'd0, sample_strobe}, 32'd0);
        reset = 1'b0;

        // 6: tlast on every 4th word with the macro, never without
        axis.tready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cap(400 + 2 * k);
            cap(401 + 2 * k);
            chk($sformatf("t6_tdata%0d", k), axis.tdata, word(400 + 2 * k));
`ifdef GPS_IQ_PACK_TLAST_EN
            chk($sformatf("t6_tlast%0d", k), {31'd0, axis.tlast}, {31'd0, k % 4 == 3});
`else
            chk($sformatf("t6_tlast%0d", k), {31'd0, axis.tlast}, 32'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
